// File: rtl/cr_cfg_loader_pkg.sv
// Shared definitions for the configuration loader: FSM encoding,
// register-block addresses and the standard-to-word-count table.
package cr_cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_CTRL  = 3'd1,
        ST_GET_W    = 3'd2,
        ST_WR_VEC   = 3'd3,
        ST_WAIT_SYM = 3'd4,
        ST_ERR      = 3'd5
    } state_e;

    // Register-block addresses
    localparam logic [1:0] ADR_CTRL = 2'b00;
    localparam logic [1:0] ADR_VEC  = 2'b01;
    localparam logic [1:0] ADR_CLR  = 2'b10;

    // Allocation-vector length per standard
    localparam int              NW_W    = 8;
    localparam logic [NW_W-1:0] NW_STD0 = 8'd4;
    localparam logic [NW_W-1:0] NW_STD1 = 8'd16;
    localparam logic [NW_W-1:0] NW_STD2 = 8'd128;
    localparam logic [NW_W-1:0] NW_STD3 = 8'd0;

    function automatic logic [NW_W-1:0] std_to_nw(input logic [1:0] std);
        logic [NW_W-1:0] nw;
        case (std)
            2'b00:   nw = NW_STD0;
            2'b01:   nw = NW_STD1;
            2'b10:   nw = NW_STD2;
            2'b11:   nw = NW_STD3;
            default: nw = NW_STD3;
        endcase
        return nw;
    endfunction

endpackage

// File: rtl/cr_cfg_loader_tmo.sv
// Bus-strobe watchdog: counts cycles while the strobe is held and flags
// the last permitted cycle. The count restarts whenever the strobe is low,
// so every rising strobe begins a fresh window of LIMIT cycles.
module wb_tmo_cnt #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic hit
);

    localparam int            CW   = (LIMIT < 2) ? 1 : $clog2(LIMIT);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter: advances while enabled, saturates on the last cycle, clears when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r != LAST) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign hit = en && (cnt_r == LAST);

endmodule

// File: rtl/cr_cfg_loader.sv
// Configuration loader: writes a control word and an allocation vector into
// the modem register block over a simple strobe/ack bus, then arms the
// vector on the next OFDM symbol boundary. A stalled bus aborts the load.
module cr_cfg_loader
    import cr_cfg_loader_pkg::*;
#(
    parameter int TMO_CYC = 255,
    parameter int AW      = 8
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CFG_STB,
    input  logic [1:0]  CFG_STD,
    input  logic [1:0]  CFG_MOD,
    output logic        CFG_BUSY,
    output logic        CFG_DONE,
    output logic        CFG_ERR,
    input  logic [31:0] VW_DAT,
    input  logic        VW_VLD,
    output logic        VW_RDY,
    output logic [31:0] M_DAT_O,
    output logic [1:0]  M_ADR_O,
    output logic        M_WE_O,
    output logic        M_STB_O,
    input  logic        M_ACK_I,
    input  logic        SYM_BND,
    output logic        VEC_LD_O
);

    state_e        state_r;
    state_e        state_nxt_s;
    logic [AW-1:0] nw_r;
    logic [AW-1:0] wcnt_r;
    logic [31:0]   dat_r;
    logic          err_r;

    logic start_s;
    logic take_w_s;
    logic inc_s;
    logic set_err_s;
    logic sym_ld_s;
    logic stb_s;
    logic tmo_hit_s;
    logic last_w_s;

    // The strobe is a pure decode of the state register, so it always falls
    // for at least one cycle after every completed or aborted write.
    assign stb_s    = (state_r == ST_WR_CTRL) || (state_r == ST_WR_VEC);
    assign last_w_s = ((wcnt_r + AW'(1)) == nw_r);

    wb_tmo_cnt #(
        .LIMIT (TMO_CYC)
    ) u_tmo (
        .clk   (CLK_I),
        .rst_n (RST_I),
        .en    (stb_s),
        .hit   (tmo_hit_s)
    );

    // State register
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and datapath load enables; ACK wins over a coincident timeout
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        take_w_s    = 1'b0;
        inc_s       = 1'b0;
        set_err_s   = 1'b0;
        sym_ld_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (CFG_STB) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_WR_CTRL;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_WR_CTRL: begin
                if (M_ACK_I) begin
                    if (nw_r != '0) begin
                        state_nxt_s = ST_GET_W;
                    end else begin
                        state_nxt_s = ST_WAIT_SYM;
                    end
                end else if (tmo_hit_s) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_WR_CTRL;
                end
            end
            ST_GET_W: begin
                if (VW_VLD) begin
                    take_w_s    = 1'b1;
                    state_nxt_s = ST_WR_VEC;
                end else begin
                    state_nxt_s = ST_GET_W;
                end
            end
            ST_WR_VEC: begin
                if (M_ACK_I) begin
                    inc_s = 1'b1;
                    if (last_w_s) begin
                        state_nxt_s = ST_WAIT_SYM;
                    end else begin
                        state_nxt_s = ST_GET_W;
                    end
                end else if (tmo_hit_s) begin
                    set_err_s   = 1'b1;
                    state_nxt_s = ST_ERR;
                end else begin
                    state_nxt_s = ST_WR_VEC;
                end
            end
            ST_WAIT_SYM: begin
                if (SYM_BND) begin
                    sym_ld_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_SYM;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Datapath: word count, write-data register and sticky error flag
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            nw_r   <= '0;
            wcnt_r <= '0;
            dat_r  <= 32'h0000_0000;
            err_r  <= 1'b0;
        end else begin
            if (start_s) begin
                nw_r   <= AW'(std_to_nw(CFG_STD));
                wcnt_r <= '0;
                dat_r  <= {28'h000_0000, CFG_MOD, CFG_STD};
            end else if (take_w_s) begin
                dat_r  <= VW_DAT;
            end else if (inc_s) begin
                wcnt_r <= wcnt_r + AW'(1);
            end else begin
                dat_r  <= dat_r;
            end

            if (start_s) begin
                err_r <= 1'b0;
            end else if (set_err_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign M_STB_O  = stb_s;
    assign M_WE_O   = stb_s;
    assign M_ADR_O  = (state_r == ST_WR_VEC) ? ADR_VEC : ADR_CTRL;
    assign M_DAT_O  = dat_r;
    assign VW_RDY   = (state_r == ST_GET_W);
    assign CFG_BUSY = (state_r != ST_IDLE) && (state_r != ST_ERR);
    assign CFG_ERR  = err_r;
    assign CFG_DONE = sym_ld_s;
    assign VEC_LD_O = sym_ld_s;

endmodule

// File: tb/tb_cr_cfg_loader.sv
// Self-checking bench for cr_cfg_loader: a bus/vector-source environment
// records every completed write, and each load is compared against the
// write list expected from the requested standard, modulation and words.
module tb_cr_cfg_loader;

    localparam int TMO = 255;

    logic        CLK_I;
    logic        RST_I;
    logic        CFG_STB;
    logic [1:0]  CFG_STD;
    logic [1:0]  CFG_MOD;
    logic        CFG_BUSY;
    logic        CFG_DONE;
    logic        CFG_ERR;
    logic [31:0] VW_DAT = 32'h0;
    logic        VW_VLD = 1'b0;
    logic        VW_RDY;
    logic [31:0] M_DAT_O;
    logic [1:0]  M_ADR_O;
    logic        M_WE_O;
    logic        M_STB_O;
    logic        M_ACK_I = 1'b0;
    logic        SYM_BND;
    logic        VEC_LD_O;

    cr_cfg_loader #(.TMO_CYC(TMO), .AW(8)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CFG_STB(CFG_STB), .CFG_STD(CFG_STD),
        .CFG_MOD(CFG_MOD), .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE),
        .CFG_ERR(CFG_ERR), .VW_DAT(VW_DAT), .VW_VLD(VW_VLD), .VW_RDY(VW_RDY),
        .M_DAT_O(M_DAT_O), .M_ADR_O(M_ADR_O), .M_WE_O(M_WE_O),
        .M_STB_O(M_STB_O), .M_ACK_I(M_ACK_I), .SYM_BND(SYM_BND),
        .VEC_LD_O(VEC_LD_O)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    int n_chk = 0;
    int n_err = 0;

    // Environment state (env block writes, main sequence only reads)
    logic [33:0] obs_q[$];
    int          stb_cnt    = 0;
    int          last_run   = 0;
    int          stable_bad = 0;
    int          vec_ld_cnt = 0;
    int          done_cnt   = 0;
    int          rdy_seen   = 0;
    int          widx       = 0;
    bit          vw_pend    = 1'b0;
    logic [1:0]  hold_adr   = 2'b00;
    logic [31:0] hold_dat   = 32'h0;

    // Knobs (main sequence writes, env block only reads)
    logic [31:0] vw_q[$];
    int          vw_skip_to    = 0;
    int          ack_dly       = 0;
    bit          ack_block_vec = 1'b0;
    int          vld_pct       = 100;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int nw_of(input logic [1:0] std);
        case (std)
            2'b00:   return 4;
            2'b01:   return 16;
            2'b10:   return 128;
            default: return 0;
        endcase
    endfunction

    // Bus slave, write recorder and vector-word source, evaluated mid-low-phase
    always @(negedge CLK_I) begin
        #1;
        if (M_STB_O) begin
            stb_cnt++;
            if (stb_cnt == 1) begin
                hold_adr = M_ADR_O;
                hold_dat = M_DAT_O;
            end else if (M_ADR_O !== hold_adr || M_DAT_O !== hold_dat) begin
                stable_bad++;
            end
            M_ACK_I = !(ack_block_vec && M_ADR_O == 2'b01) && (stb_cnt > ack_dly);
            if (M_ACK_I) obs_q.push_back({M_ADR_O, M_DAT_O});
        end else begin
            if (stb_cnt != 0) last_run = stb_cnt;
            stb_cnt = 0;
            M_ACK_I = 1'b0;
        end
        if (VEC_LD_O) vec_ld_cnt++;
        if (CFG_DONE) done_cnt++;
        if (VW_RDY)   rdy_seen++;
        if (vw_pend) widx++;
        vw_pend = 1'b0;
        if (widx < vw_skip_to) widx = vw_skip_to;
        VW_VLD  = (widx < vw_q.size()) && ($urandom_range(99) < vld_pct);
        VW_DAT  = VW_VLD ? vw_q[widx] : $urandom();
        vw_pend = VW_VLD && VW_RDY;
    end

    // Queue fresh vector words for the next load, discarding any leftovers
    task automatic new_words(input int n, input bit fixed);
        vw_skip_to = vw_q.size();
        for (int i = 0; i < n; i++) begin
            if (fixed) vw_q.push_back(32'hA0 + 32'(i));
            else       vw_q.push_back($urandom());
        end
    endtask

    task automatic pulse_cfg(input logic [1:0] std, input logic [1:0] mod);
        @(negedge CLK_I);
        CFG_STD = std;
        CFG_MOD = mod;
        CFG_STB = 1'b1;
        @(negedge CLK_I);
        CFG_STB = 1'b0;
        CFG_STD = 2'($urandom());
        CFG_MOD = 2'($urandom());
    endtask

    // One complete load with optional spurious CFG_STB/SYM_BND while busy
    task automatic run_load(input logic [1:0] std, input logic [1:0] mod, input int adly,
                            input int pct, input bit noise, input bit fixed);
        logic [33:0] exp_q[$];
        int ob, ld0, dn0, rd0, sb0, cyc;
        bit ok;
        int nw = nw_of(std);
        ack_dly = adly;
        vld_pct = pct;
        new_words(nw, fixed);
        exp_q.push_back({2'b00, 28'h0, mod, std});
        for (int i = 0; i < nw; i++) exp_q.push_back({2'b01, vw_q[vw_skip_to + i]});
        ob  = obs_q.size();
        ld0 = vec_ld_cnt;
        dn0 = done_cnt;
        rd0 = rdy_seen;
        sb0 = stable_bad;
        pulse_cfg(std, mod);
        #2;
        check_val("busy_start", CFG_BUSY, 1);
        check_val("err_clr", CFG_ERR, 0);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < 6000 && !ok) begin
            @(negedge CLK_I);
            CFG_STB = noise && (cyc == 1 || cyc == 4);
            SYM_BND = noise && (cyc == 1 || cyc == 4);
            #2;
            cyc++;
            if (obs_q.size() - ob >= exp_q.size() && !M_STB_O) ok = 1'b1;
        end
        CFG_STB = 1'b0;
        SYM_BND = 1'b0;
        check_val("load_tmo", ok, 1);
        repeat (2) @(negedge CLK_I);
        #2;
        check_val("busy_wait", CFG_BUSY, 1);
        check_val("no_early_ld", vec_ld_cnt - ld0, 0);
        check_val("n_wr", obs_q.size() - ob, exp_q.size());
        for (int i = 0; i < exp_q.size() && ob + i < obs_q.size(); i++)
            check_val("wr", obs_q[ob + i], exp_q[i]);
        check_val("stable", stable_bad - sb0, 0);
        if (nw == 0) check_val("no_rdy", rdy_seen - rd0, 0);
        @(negedge CLK_I);
        SYM_BND = 1'b1;
        #2;
        check_val("vec_ld", VEC_LD_O, 1);
        check_val("done", CFG_DONE, 1);
        @(negedge CLK_I);
        SYM_BND = 1'b0;
        #2;
        check_val("idle", CFG_BUSY, 0);
        check_val("n_ld", vec_ld_cnt - ld0, 1);
        check_val("n_done", done_cnt - dn0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ob, cyc;
        logic [1:0] s, m;
        RST_I   = 1'b0;
        CFG_STB = 1'b0;
        CFG_STD = 2'b00;
        CFG_MOD = 2'b00;
        SYM_BND = 1'b0;
        #12;
        check_val("rst_ctl", {CFG_BUSY, CFG_DONE, CFG_ERR, VW_RDY, M_STB_O, M_WE_O, VEC_LD_O, M_ADR_O}, 0);
        check_val("rst_dat", M_DAT_O, 0);
        @(negedge CLK_I);
        RST_I = 1'b1;
        repeat (2) @(negedge CLK_I);

        // STD=00 MOD=10, zero-wait ACK, words A0..A3
        run_load(2'b00, 2'b10, 0, 100, 1'b0, 1'b1);
        check_val("ctrl_dat", obs_q[0], {2'b00, 32'h8});
        // STD=11: control write only
        run_load(2'b11, 2'b01, 0, 100, 1'b0, 1'b0);
        // STD=10, toggling VW_VLD, ACK after 3 wait cycles
        run_load(2'b10, 2'b11, 3, 50, 1'b0, 1'b0);
        // spurious CFG_STB and SYM_BND mid-load
        run_load(2'b01, 2'b01, 1, 60, 1'b1, 1'b0);
        // randomized loads
        for (int k = 0; k < 6; k++) begin
            s = 2'($urandom_range(3));
            m = 2'($urandom_range(3));
            run_load(s, m, $urandom_range(2), $urandom_range(100, 30), (s != 2'b11) && k[0], 1'b0);
        end

        // ACK withheld on vector writes: abort after TMO cycles of strobe
        ack_block_vec = 1'b1;
        ack_dly = 0;
        vld_pct = 100;
        new_words(4, 1'b0);
        ob = obs_q.size();
        pulse_cfg(2'b00, 2'b01);
        cyc = 0;
        while (cyc < 600 && !CFG_ERR) begin
            @(negedge CLK_I);
            #2;
            cyc++;
        end
        check_val("tmo_err", CFG_ERR, 1);
        check_val("tmo_run", last_run, TMO);
        check_val("tmo_busy", CFG_BUSY, 0);
        check_val("tmo_stb", M_STB_O, 0);
        check_val("tmo_nwr", obs_q.size() - ob, 1);
        ob = vec_ld_cnt;
        @(negedge CLK_I);
        SYM_BND = 1'b1;
        @(negedge CLK_I);
        SYM_BND = 1'b0;
        #2;
        check_val("tmo_no_ld", vec_ld_cnt - ob, 0);
        check_val("err_sticky", CFG_ERR, 1);
        ack_block_vec = 1'b0;
        run_load(2'b00, 2'b01, 1, 100, 1'b0, 1'b0);

        // reset during word 7 of an STD=01 load
        ack_dly = 0;
        vld_pct = 100;
        new_words(16, 1'b0);
        ob = obs_q.size();
        pulse_cfg(2'b01, 2'b10);
        cyc = 0;
        while (cyc < 500 && obs_q.size() - ob < 7) begin
            @(negedge CLK_I);
            #2;
            cyc++;
        end
        check_val("mid_wr", obs_q.size() - ob, 7);
        #1;
        RST_I = 1'b0;
        #1;
        check_val("mid_rst_ctl", {CFG_BUSY, CFG_DONE, CFG_ERR, VW_RDY, M_STB_O, M_WE_O, VEC_LD_O, M_ADR_O}, 0);
        check_val("mid_rst_dat", M_DAT_O, 0);
        repeat (2) @(negedge CLK_I);
        RST_I = 1'b1;
        ob = obs_q.size();
        repeat (5) @(negedge CLK_I);
        #2;
        check_val("no_resume_busy", CFG_BUSY, 0);
        check_val("no_resume_wr", obs_q.size() - ob, 0);
        run_load(2'b01, 2'b11, 0, 100, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cr_cfg_loader.md
CR_CFG_LOADER -- requirements
Module: cr_cfg_loader

Interface
REQ-001 SHALL have parameter TMO_CYC, default 255, giving the maximum cycles M_STB_O may wait for M_ACK_I before abort.
REQ-002 SHALL have parameter AW, default 8, giving the width of the internal word counter (must hold 128).
REQ-003 SHALL have port CLK_I, in, 1: the single clock, rising edge.
REQ-004 SHALL have port RST_I, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port CFG_STB, in, 1: one-cycle request to start a configuration load.
REQ-006 SHALL have port CFG_STD, in, 2: standard, sampled with CFG_STB.
REQ-007 SHALL have port CFG_MOD, in, 2: modulation, sampled with CFG_STB.
REQ-008 SHALL have port CFG_BUSY, out, 1: load in progress.
REQ-009 SHALL have port CFG_DONE, out, 1: one-cycle pulse when a load completes.
REQ-010 SHALL have port CFG_ERR, out, 1: sticky flag set on ACK timeout.
REQ-011 SHALL have port VW_DAT, in, 32: allocation-vector word.
REQ-012 SHALL have port VW_VLD, in, 1: VW_DAT is valid.
REQ-013 SHALL have port VW_RDY, out, 1: word accepted when VW_VLD and VW_RDY are both high.
REQ-014 SHALL have port M_DAT_O, out, 32: write data to the register block.
REQ-015 SHALL have port M_ADR_O, out, 2: register address (00 = control, 01 = vector).
REQ-016 SHALL have ports M_WE_O and M_STB_O, out, 1 each: write strobe pair.
REQ-017 SHALL have port M_ACK_I, in, 1: slave acknowledge (may be combinational).
REQ-018 SHALL have port SYM_BND, in, 1: OFDM symbol-boundary pulse.
REQ-019 SHALL have port VEC_LD_O, out, 1: one-cycle vector-load pulse to the register block.

Function
REQ-020 SHALL implement FSM states IDLE, WR_CTRL, GET_W, WR_VEC, WAIT_SYM and ERR.
REQ-021 IDLE: on CFG_STB, latch STD/MOD, clear CFG_ERR, compute NW, and go to WR_CTRL next cycle.
REQ-022 NW SHALL be 4, 16, 128 or 0 for STD 00, 01, 10, 11 respectively.
REQ-023 WR_CTRL: M_ADR_O=00, M_DAT_O={28'b0,MOD,STD}, M_WE_O=M_STB_O=1.
REQ-024 On leaving WR_CTRL via ACK, go to GET_W if NW>0, else WAIT_SYM.
REQ-025 GET_W: VW_RDY=1 and M_STB_O=0; on VW_VLD, register VW_DAT into M_DAT_O and go to WR_VEC.
REQ-026 WR_VEC: M_ADR_O=01, M_WE_O=M_STB_O=1, with address and data held stable until M_ACK_I.
REQ-027 WR_VEC: on ACK, increment the word counter; when counter+1==NW go to WAIT_SYM, else go to GET_W.
REQ-028 Every write SHALL complete in the cycle where M_STB_O and M_ACK_I are both high, and M_STB_O SHALL be low the following cycle; minimum 2 cycles per vector word.
REQ-029 VW_RDY SHALL be 0 in every state except GET_W.
REQ-030 WAIT_SYM: on SYM_BND, assert VEC_LD_O and CFG_DONE for exactly that one cycle, then go to IDLE.
REQ-031 A SYM_BND arriving in any other state SHALL be ignored.
REQ-032 CFG_STB SHALL be ignored when not in IDLE; no queueing.
REQ-033 CFG_BUSY SHALL be high in every state except IDLE and ERR.
REQ-034 A wait counter SHALL reset each time M_STB_O rises; reaching TMO_CYC without ACK SHALL drop M_STB_O, set CFG_ERR, and enter ERR.
REQ-035 ERR: all strobes SHALL be low; CFG_STB SHALL restart as from IDLE; no VEC_LD_O is issued for the aborted load.
REQ-036 ACK in the same cycle as the timeout SHALL count as success.

Reset
REQ-037 On RST_I low, the FSM SHALL return to IDLE immediately, even mid-transfer.
REQ-038 During reset, all counters and M_DAT_O SHALL be 0, and M_STB_O, M_WE_O, VW_RDY, VEC_LD_O, CFG_DONE, CFG_BUSY and CFG_ERR SHALL be 0.
REQ-039 An interrupted load SHALL not be resumed after reset.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding, the register addresses (00 control, 01 vector, 10 clear), and the STD-to-NW word-count constants.
REQ-041 No sub-module is required; the timeout counter may be a small generic counter sub-module, wb_tmo_cnt.

Verification
REQ-042 STD=00, MOD=10, zero-wait ACK, 4 words A0..A3 -> ctrl write data 0x8, four vector writes in order, VEC_LD_O and CFG_DONE on the first SYM_BND.
REQ-043 STD=11 -> ctrl write only, zero vector writes, VW_RDY never high, VEC_LD_O on SYM_BND.
REQ-044 STD=10 with VW_VLD toggling and ACK delayed 3 cycles -> exactly 128 writes, data stable while M_STB_O is high, word order preserved.
REQ-045 M_ACK_I held low in WR_VEC -> M_STB_O drops after 255 cycles, CFG_ERR=1, CFG_BUSY=0, no VEC_LD_O; a new CFG_STB clears CFG_ERR.
REQ-046 RST_I low during word 7 of STD=01 -> all outputs 0 at once; a new CFG_STB after reset restarts from the control write.
REQ-047 CFG_STB and SYM_BND during a load -> no effect; only one CFG_DONE per accepted request.
